// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: grants the CPU MEM stage or the DMA/debug requester one
// access at a time, holds the command for MEM_LAT cycles, then returns data/err for a cycle.
module dmem_arbiter #(
    parameter int DATA_W     = 64,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [DATA_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_err,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [DATA_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_done,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam int CW = $clog2(MEM_LAT + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] LAT_LAST   = CW'(MEM_LAT - 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    logic [1:0]        state;
    logic [CW-1:0]     cyc_cnt;
    logic [SW-1:0]     starve_cnt;
    logic              win_dma;

    logic              idle;
    logic              contested;
    logic              dma_win;
    logic              misaligned;
    logic              sel_we;
    logic [DATA_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [DATA_W-1:0] rd_data;

    // Grant is gated by reset so no port sees gnt while the block is held in reset.
    assign idle       = (state == S_IDLE) && reset;
    assign contested  = cpu_req && dma_req;
    assign dma_win    = dma_req && (!cpu_req || (starve_cnt >= STARVE_LIM));
    assign cpu_gnt    = idle && cpu_req && !dma_win;
    assign dma_gnt    = idle && dma_win;
    assign sel_we     = dma_win ? dma_we    : cpu_we;
    assign sel_addr   = dma_win ? dma_addr  : cpu_addr;
    assign sel_wdata  = dma_win ? dma_wdata : cpu_wdata;
    assign misaligned = |sel_addr[2:0];
    assign rd_data    = mem_we ? '0 : mem_rdata;
    assign cpu_stall  = cpu_req && !cpu_done;

    // mem_we/mem_addr/mem_wdata double as the command registers; they are only
    // loaded for aligned commands so the memory port stays quiet otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            cyc_cnt    <= '0;
            starve_cnt <= '0;
            win_dma    <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_done   <= 1'b0;
            cpu_rdata  <= '0;
            cpu_err    <= 1'b0;
            dma_done   <= 1'b0;
            dma_rdata  <= '0;
            dma_err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cpu_gnt || dma_gnt) begin
                        win_dma <= dma_gnt;
                        if (dma_gnt)
                            starve_cnt <= '0;
                        else if (contested && (starve_cnt < STARVE_LIM))
                            starve_cnt <= starve_cnt + 1'b1;
                        if (misaligned) begin
                            state    <= S_RESP;
                            cpu_done <= cpu_gnt;
                            cpu_err  <= cpu_gnt;
                            dma_done <= dma_gnt;
                            dma_err  <= dma_gnt;
                        end else begin
                            state     <= S_ACCESS;
                            cyc_cnt   <= LAT_LAST;
                            mem_en    <= 1'b1;
                            mem_we    <= sel_we;
                            mem_addr  <= sel_addr;
                            mem_wdata <= sel_wdata;
                        end
                    end
                end
                S_ACCESS: begin
                    if (cyc_cnt == '0) begin
                        state     <= S_RESP;
                        mem_en    <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        if (win_dma) begin
                            dma_done  <= 1'b1;
                            dma_rdata <= rd_data;
                        end else begin
                            cpu_done  <= 1'b1;
                            cpu_rdata <= rd_data;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    state     <= S_IDLE;
                    cpu_done  <= 1'b0;
                    cpu_rdata <= '0;
                    cpu_err   <= 1'b0;
                    dma_done  <= 1'b0;
                    dma_rdata <= '0;
                    dma_err   <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
